// File: rtl/bus_mux_n.sv
// Registered N-source bus multiplexer with fixed lowest-index priority,
// configurable idle/conflict behaviour and multi-driver conflict tracking.
module bus_mux_n #(
   parameter int WIDTH         = 32,
   parameter int NSRC          = 24,
   parameter bit HOLD_ON_IDLE  = 1'b1,
   parameter bit CONFLICT_HOLD = 1'b0,
   parameter int SW            = $clog2(NSRC)
) (
   input  logic                  clk,
   input  logic                  clr,
   input  logic [NSRC*WIDTH-1:0] src_in,
   input  logic [NSRC-1:0]       src_en,
   input  logic                  err_clr,
   output logic [WIDTH-1:0]      bus_out,
   output logic                  bus_valid,
   output logic [SW-1:0]         bus_src,
   output logic                  conflict,
   output logic                  conflict_sticky,
   output logic [7:0]            conflict_count
);

   localparam logic [NSRC-1:0] EN_ONE = NSRC'(1);

   logic [SW-1:0]    sel;
   logic [WIDTH-1:0] sel_word;
   logic             any;
   logic             multi;
   logic             take;

   // NOTE: defaults are assigned before the loop so no path leaves sel/sel_word
   // unassigned, which would otherwise infer latches.
   always_comb begin
      sel      = '0;
      sel_word = '0;
      // Scanning downward lets the lowest set index overwrite higher ones.
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (src_en[i]) begin
            sel      = SW'(i);
            sel_word = src_in[i*WIDTH +: WIDTH];
         end
      end
   end

   assign any   = |src_en;
   assign multi = |(src_en & (src_en - EN_ONE));
   assign take  = any && !(multi && CONFLICT_HOLD);

   // NOTE: all state updates use non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         bus_out         <= '0;
         bus_valid       <= 1'b0;
         bus_src         <= '0;
         conflict        <= 1'b0;
         conflict_sticky <= 1'b0;
         conflict_count  <= 8'd0;
      end else begin
         conflict <= multi;

         if (take) begin
            bus_out   <= sel_word;
            bus_src   <= sel;
            bus_valid <= 1'b1;
         end else begin
            bus_valid <= 1'b0;
            if (!any && !HOLD_ON_IDLE)
               bus_out <= '0;
         end

         // A clear coinciding with a conflict restarts the status at one event.
         if (err_clr) begin
            conflict_sticky <= multi;
            conflict_count  <= multi ? 8'd1 : 8'd0;
         end else if (multi) begin
            conflict_sticky <= 1'b1;
            if (conflict_count != 8'hFF)
               conflict_count <= conflict_count + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_bus_mux_n.sv
// Randomised and directed bench for bus_mux_n; three instances cover the
// idle-hold, idle-zero and conflict-hold configurations against one model.
module tb_bus_mux_n;

   localparam int W  = 32;
   localparam int N  = 24;
   localparam int SW = $clog2(N);
   localparam int NI = 3;

   localparam bit HOLD_CFG  [NI] = '{1'b1, 1'b0, 1'b1};
   localparam bit CHOLD_CFG [NI] = '{1'b0, 1'b0, 1'b1};

   logic            clk = 1'b0;
   logic            clr = 1'b1;
   logic [N*W-1:0]  src_in = '0;
   logic [N-1:0]    src_en = '0;
   logic            err_clr = 1'b0;

   logic [W-1:0]    bo  [NI];
   logic            bv  [NI];
   logic [SW-1:0]   bs  [NI];
   logic            cf  [NI];
   logic            cs  [NI];
   logic [7:0]      cc  [NI];

   logic [W-1:0]    words [N];

   typedef struct {
      logic [W-1:0] bus;
      logic         valid;
      int           src;
      logic         conflict;
      logic         sticky;
      int           count;
   } model_t;

   model_t m [NI];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bus_mux_n #(.WIDTH(W), .NSRC(N), .HOLD_ON_IDLE(1'b1), .CONFLICT_HOLD(1'b0)) u_hold (
      .clk(clk), .clr(clr), .src_in(src_in), .src_en(src_en), .err_clr(err_clr),
      .bus_out(bo[0]), .bus_valid(bv[0]), .bus_src(bs[0]), .conflict(cf[0]),
      .conflict_sticky(cs[0]), .conflict_count(cc[0]));

   bus_mux_n #(.WIDTH(W), .NSRC(N), .HOLD_ON_IDLE(1'b0), .CONFLICT_HOLD(1'b0)) u_zero (
      .clk(clk), .clr(clr), .src_in(src_in), .src_en(src_en), .err_clr(err_clr),
      .bus_out(bo[1]), .bus_valid(bv[1]), .bus_src(bs[1]), .conflict(cf[1]),
      .conflict_sticky(cs[1]), .conflict_count(cc[1]));

   bus_mux_n #(.WIDTH(W), .NSRC(N), .HOLD_ON_IDLE(1'b1), .CONFLICT_HOLD(1'b1)) u_chold (
      .clk(clk), .clr(clr), .src_in(src_in), .src_en(src_en), .err_clr(err_clr),
      .bus_out(bo[2]), .bus_valid(bv[2]), .bus_src(bs[2]), .conflict(cf[2]),
      .conflict_sticky(cs[2]), .conflict_count(cc[2]));

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic pack_words();
      for (int i = 0; i < N; i++) src_in[i*W +: W] = words[i];
   endtask

   task automatic model_reset();
      for (int k = 0; k < NI; k++) m[k] = '{bus: '0, valid: 1'b0, src: 0, conflict: 1'b0, sticky: 1'b0, count: 0};
   endtask

   // Behavioural rules evaluated on the inputs present at the clock edge.
   task automatic model_edge();
      int n;
      int low;
      n   = $countones(src_en);
      low = -1;
      for (int i = N - 1; i >= 0; i--) if (src_en[i]) low = i;
      for (int k = 0; k < NI; k++) begin
         if (n == 1 || (n > 1 && !CHOLD_CFG[k])) begin
            m[k].bus   = words[low];
            m[k].src   = low;
            m[k].valid = 1'b1;
         end else begin
            m[k].valid = 1'b0;
            if (n == 0 && !HOLD_CFG[k]) m[k].bus = '0;
         end
         m[k].conflict = (n > 1);
         if (err_clr) begin
            m[k].sticky = (n > 1);
            m[k].count  = (n > 1) ? 1 : 0;
         end else if (n > 1) begin
            m[k].sticky = 1'b1;
            m[k].count  = (m[k].count < 255) ? m[k].count + 1 : 255;
         end
      end
   endtask

   task automatic compare_all(input string ctx);
      for (int k = 0; k < NI; k++) begin
         check($sformatf("%s/i%0d bus_out", ctx, k),   64'(bo[k]), 64'(m[k].bus));
         check($sformatf("%s/i%0d bus_valid", ctx, k), 64'(bv[k]), 64'(m[k].valid));
         check($sformatf("%s/i%0d bus_src", ctx, k),   64'(bs[k]), 64'(m[k].src));
         check($sformatf("%s/i%0d conflict", ctx, k),  64'(cf[k]), 64'(m[k].conflict));
         check($sformatf("%s/i%0d sticky", ctx, k),    64'(cs[k]), 64'(m[k].sticky));
         check($sformatf("%s/i%0d count", ctx, k),     64'(cc[k]), 64'(m[k].count));
      end
   endtask

   task automatic check_zero(input string ctx);
      for (int k = 0; k < NI; k++) begin
         check($sformatf("%s/i%0d bus_out", ctx, k), 64'(bo[k]), 64'd0);
         check($sformatf("%s/i%0d flags", ctx, k),   64'({bv[k], cf[k], cs[k]}), 64'd0);
         check($sformatf("%s/i%0d bus_src", ctx, k), 64'(bs[k]), 64'd0);
         check($sformatf("%s/i%0d count", ctx, k),   64'(cc[k]), 64'd0);
      end
   endtask

   task automatic step(input logic [N-1:0] en, input logic ec, input string ctx);
      @(negedge clk);
      src_en  = en;
      err_clr = ec;
      pack_words();
      @(posedge clk);
      model_edge();
      #1;
      compare_all(ctx);
   endtask

   // Asynchronous clear asserted between edges; an edge while held must be ignored.
   task automatic async_clear(input string ctx);
      #2;
      clr = 1'b1;
      #1;
      check_zero({ctx, "/assert"});
      model_reset();
      src_en  = N'($urandom) | N'(3);
      err_clr = 1'b1;
      @(posedge clk);
      #1;
      check_zero({ctx, "/held"});
      @(negedge clk);
      src_en  = '0;
      err_clr = 1'b0;
      clr     = 1'b0;
   endtask

   function automatic logic [N-1:0] multi_en();
      int a;
      int b;
      a = $urandom_range(N - 1);
      b = (a + 1 + $urandom_range(N - 2)) % N;
      return (N'(1) << a) | (N'(1) << b) | (N'($urandom) & N'($urandom));
   endfunction

   initial begin
      logic [N-1:0] en;
      for (int i = 0; i < N; i++) words[i] = $urandom;
      pack_words();
      model_reset();

      repeat (2) @(posedge clk);
      #1;
      check_zero("por");
      @(negedge clk);
      clr = 1'b0;

      // Reset pulse then basic select of source 5.
      step(N'(1) << 1, 1'b0, "pre");
      async_clear("rst1");
      words[5] = 32'hDEADBEEF;
      step(N'(1) << 5, 1'b0, "sel5");
      check("sel5 anchor bus", 64'(bo[0]), 64'hDEADBEEF);
      check("sel5 anchor src", 64'(bs[0]), 64'd5);
      check("sel5 anchor valid", 64'(bv[0]), 64'd1);

      // Streaming sweep with no bubbles.
      for (int i = 0; i < N; i++) words[i] = W'(i) * 32'h01010101;
      for (int i = 0; i < N; i++) begin
         step(N'(1) << i, 1'b0, $sformatf("stream%0d", i));
         check($sformatf("stream%0d anchor", i), 64'(bo[1]), 64'(W'(i) * 32'h01010101));
      end

      // Idle behaviour for both HOLD_ON_IDLE settings.
      words[3] = 32'h12345678;
      step(N'(1) << 3, 1'b0, "idle_sel");
      for (int i = 0; i < 10; i++) step('0, 1'b0, $sformatf("idle%0d", i));
      check("idle hold anchor", 64'(bo[0]), 64'h12345678);
      check("idle zero anchor", 64'(bo[1]), 64'd0);

      // Single conflict on sources 2 and 7, then the pulse drops.
      step((N'(1) << 2) | (N'(1) << 7), 1'b0, "conf");
      check("conf anchor src", 64'(bs[0]), 64'd2);
      check("conf anchor hold src", 64'(bs[2]), 64'd3);
      step(N'(1) << 4, 1'b0, "conf_after");

      // Saturation, then clear coinciding with a conflict, then clear alone.
      for (int i = 0; i < 300; i++) step(multi_en(), 1'b0, "sat");
      check("sat anchor", 64'(cc[0]), 64'd255);
      step(multi_en(), 1'b1, "clr_conf");
      check("clr_conf anchor", 64'(cc[2]), 64'd1);
      step('0, 1'b1, "clr_only");
      check("clr_only anchor", 64'({cs[0], cc[0]}), 64'd0);

      // Async clear mid-stream and after a conflict; count restarts from zero.
      for (int i = 0; i < 4; i++) step(N'(1) << (i + 8), 1'b0, "mid_stream");
      async_clear("rst2");
      step(multi_en(), 1'b0, "pre_rst3");
      step(multi_en(), 1'b0, "pre_rst3b");
      async_clear("rst3");
      step(multi_en(), 1'b0, "post_rst3");
      check("post_rst3 anchor", 64'(cc[0]), 64'd1);

      // Randomised traffic mixing idle, one-hot, conflicts and clears.
      for (int t = 0; t < 400; t++) begin
         if ($urandom_range(7) == 0)
            for (int i = 0; i < N; i++) words[i] = $urandom;
         case ($urandom_range(3))
            0:       en = '0;
            1, 2:    en = N'(1) << $urandom_range(N - 1);
            default: en = multi_en();
         endcase
         step(en, ($urandom_range(15) == 0), "rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bus_mux_n.md
# bus_mux_n

Parametrised, registered successor to the datapath's 32-bit source-select bus. It selects one of NSRC source words onto a shared bus using one-hot output enables with fixed lowest-index priority, and registers the result. It can hold or zero the bus when idle, and it detects and counts multi-driver conflicts. It sits between the register file, special registers (HI/LO/Z/PC/MDR/InPort/C) and every bus consumer in the datapath.

## Interface
- WIDTH, 32: bus word width in bits.
- NSRC, 24: number of sources. Legal range is 2..64.
- HOLD_ON_IDLE, 1: idle-cycle behaviour. 1 = bus_out keeps its last value; 0 = bus_out goes to 0.
- CONFLICT_HOLD, 0: conflict behaviour. 0 = the lowest index wins; 1 = bus_out holds its previous value on a conflict.
- SW, $clog2(NSRC): width of the source index.

Ports:
- clk  in  1  single clock, rising edge.
- clr  in  1  asynchronous, active-high reset.
- src_in  in  NSRC*WIDTH  packed source words. Source i occupies bits [i*WIDTH +: WIDTH].
- src_en  in  NSRC  per-source output enables. One-hot is expected.
- err_clr  in  1  synchronous clear of the conflict status.
- bus_out  out  WIDTH  registered bus value.
- bus_valid  out  1  high for the cycle after any src_en bit was set.
- bus_src  out  SW  index of the source that produced bus_out.
- conflict  out  1  one-cycle pulse, registered: two or more enables were high in the previous cycle.
- conflict_sticky  out  1  set by any conflict; cleared only by err_clr or clr.
- conflict_count  out  8  saturating count of conflict cycles.

## Operation
- Each cycle, sel = lowest index i with src_en[i] = 1, and any = |src_en.
- multi = two or more src_en bits high. Compute it as (src_en & (src_en - 1)) != 0.
- Next-state rules:
  - any && !multi: bus_out <= src_in[sel], bus_src <= sel, bus_valid <= 1.
  - multi && CONFLICT_HOLD=0: same as the single-source case, using the lowest index.
  - multi && CONFLICT_HOLD=1: bus_out and bus_src hold, bus_valid <= 0.
  - !any: bus_valid <= 0, bus_src holds. bus_out holds if HOLD_ON_IDLE=1, else bus_out <= 0.
- Conflict status:
  - conflict <= multi on every edge.
  - If multi: conflict_sticky <= 1 and conflict_count <= count+1, saturating at 255.
  - err_clr and multi in the same cycle: the clear applies first. Result is sticky = 1, count = 1.
  - err_clr alone: sticky <= 0, count <= 0.
- Enables wider than NSRC do not exist, so out-of-range index selection is impossible.
- No combinational path from src_in/src_en to any output.

## Timing
- Latency is 1 cycle: src_en/src_in sampled at edge N appear on bus_out at edge N (valid after clk-to-q), i.e. consumers latch them at edge N+1.
- Back-to-back selects of different sources on consecutive cycles produce consecutive bus values with no bubble.
- clr is asynchronous and may assert at any time, mid-transfer or mid-conflict. On assertion all outputs go to 0 immediately:
  - bus_out = 0, bus_valid = 0, bus_src = 0.
  - conflict = 0, conflict_sticky = 0, conflict_count = 0.
- During clr the block ignores src_en and err_clr.
- The first edge after clr deasserts behaves as a normal cycle.
- Counter saturation: at 255, further conflicts leave the count at 255 and the sticky flag at 1.
- src_en = 0 for many cycles:
  - HOLD_ON_IDLE=1: bus_out is stable indefinitely.
  - HOLD_ON_IDLE=0: bus_out = 0 from the first idle edge onward.

## Test plan
- **Reset and basic select:** clr pulse mid-cycle, then src_en = 1<<5 with src5 = 32'hDEADBEEF. Outputs are all 0 during clr. After the next edge: bus_out = DEADBEEF, bus_src = 5, bus_valid = 1.
- **Streaming:** src_en sweeps 0..23 on consecutive cycles with src_i = i*32'h01010101. bus_out tracks one cycle behind with no gaps, and bus_src = i.
- **Idle:** with HOLD_ON_IDLE=1, select src3 = 32'h12345678 then idle 10 cycles; bus_out stays 12345678 and bus_valid = 0. Repeat with HOLD_ON_IDLE=0; bus_out = 0 after the first idle edge.
- **Conflict:** src_en = bits 2 and 7. With CONFLICT_HOLD=0: bus_src = 2, conflict pulses for 1 cycle, sticky = 1, count = 1. With CONFLICT_HOLD=1: bus_out and bus_src unchanged, bus_valid = 0.
- **Saturation and clear:** 300 consecutive conflict cycles give count = 255. Then err_clr together with a conflict gives count = 1, sticky = 1. Then err_clr alone gives count = 0, sticky = 0.
- **Async reset mid-stream:** assert clr between edges while streaming and after a conflict. All outputs are 0 before the next edge, and the count restarts from 0.
